// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: redirect vectors, ROM depth,
// FSM state encoding and a small address-range helper.
package instr_fetch_pkg;

    localparam logic [31:0] RESET_ADDR_DEF = 32'd0;
    localparam logic [31:0] ILLOP_ADDR_DEF = 32'd480;
    localparam logic [31:0] XADR_ADDR_DEF  = 32'd484;
    localparam int          IMEM_WORDS_DEF = 128;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // True when the word index of a byte address lies past the end of the ROM.
    function automatic logic out_of_rom(input logic [31:0] addr, input int words);
        logic [31:0] word_idx;
        word_idx = {2'b00, addr[31:2]};
        return word_idx >= 32'(words);
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC selection for the fetch stage: fixed-priority redirect mux
// (irq > trap_illop > branch), sequential +4, and the saved return address.
module fetch_pc_sel
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
    parameter logic [31:0] XADR_ADDR  = XADR_ADDR_DEF
) (
    input  logic [31:0] pc,
    input  logic        slot_valid,
    input  logic [31:0] slot_pc,
    input  logic        irq_act,
    input  logic        trap_act,
    input  logic        br_act,
    input  logic [31:0] br_target,
    input  logic        fire,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        redirect,
    output logic        xp_load,
    output logic [31:0] xp_next
);

    // Priority redirect mux; only the highest-priority request acts.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        pc_plus4 = pc + 32'd4;
        next_pc  = pc;
        redirect = 1'b0;
        xp_load  = 1'b0;
        xp_next  = slot_pc + 32'd4;
        if (irq_act) begin
            redirect = 1'b1;
            xp_load  = 1'b1;
            next_pc  = XADR_ADDR;
            // Return to the oldest unexecuted instruction: the slot if full, else the PC.
            xp_next  = (slot_valid ? slot_pc : pc) + 32'd4;
        end else if (trap_act) begin
            redirect = 1'b1;
            xp_load  = 1'b1;
            next_pc  = ILLOP_ADDR;
        end else if (br_act) begin
            redirect = 1'b1;
            next_pc  = {br_target[31:2], 2'b00};
        end else if (fire) begin
            next_pc  = pc + 32'd4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the ROM address, and registers the
// returned word into a valid/ready slot toward decode. Handles branch,
// illegal-op and interrupt redirects.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter logic [31:0] ILLOP_ADDR = ILLOP_ADDR_DEF,
    parameter logic [31:0] XADR_ADDR  = XADR_ADDR_DEF,
    parameter int          IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        trap_illop,
    input  logic        irq,
    input  logic        halt_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        out_fault,
    output logic        xp_valid,
    output logic [31:0] xp
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic [31:0]  xp_next;
    logic         redirect;
    logic         xp_load;
    logic         irq_act;
    logic         trap_act;
    logic         br_act;
    logic         fire;
    logic         fault_now;

    // irq is only honoured in RUN; trap and branch also apply in HALT; BOOT ignores all.
    assign irq_act   = irq && (state_q == ST_RUN);
    assign trap_act  = trap_illop && (state_q != ST_BOOT);
    assign br_act    = br_valid && (state_q != ST_BOOT);
    assign fire      = (state_q == ST_RUN) && !halt_req && !(irq_act || trap_act || br_act)
                       && (!out_valid || out_ready);
    assign fault_now = out_of_rom(pc_q, IMEM_WORDS);
    assign imem_addr = pc_q;

    fetch_pc_sel #(
        .ILLOP_ADDR (ILLOP_ADDR),
        .XADR_ADDR  (XADR_ADDR)
    ) u_pc_sel (
        .pc         (pc_q),
        .slot_valid (out_valid),
        .slot_pc    (out_pc),
        .irq_act    (irq_act),
        .trap_act   (trap_act),
        .br_act     (br_act),
        .br_target  (br_target),
        .fire       (fire),
        .pc_plus4   (pc_plus4),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .xp_load    (xp_load),
        .xp_next    (xp_next)
    );

    // Next-state logic: single BOOT cycle, then RUN/HALT following halt_req.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt_req && !redirect) state_d = ST_HALT;
            ST_HALT: if (!halt_req) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    // Program counter: holds unless a fetch fires or a redirect wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_ADDR;
        else        pc_q <= next_pc;
    end

    // Fetch/decode slot: flushed on redirect, loaded on fire, drained on ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_instr    <= 32'd0;
            out_pc       <= 32'd0;
            out_pc_plus4 <= 32'd4;
            out_fault    <= 1'b0;
        end else if (redirect) begin
            out_valid    <= 1'b0;
        end else if (fire) begin
            out_valid    <= 1'b1;
            out_instr    <= fault_now ? 32'd0 : imem_data;
            out_pc       <= pc_q;
            out_pc_plus4 <= pc_plus4;
            out_fault    <= fault_now;
        end else if (out_valid && out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    // Return-address register for r30, with a one-cycle write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xp_valid <= 1'b0;
            xp       <= 32'd0;
        end else begin
            xp_valid <= xp_load;
            if (xp_load) xp <= xp_next;
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage sitting directly upstream of the `instr` ROM. It owns the program counter and drives the ROM address. It captures the returned instruction word into a registered fetch/decode slot with a valid/ready handshake. It redirects the PC on branch/jump, illegal-op and interrupt (XADR) events, per the Beta-style vectors the processor uses.

## Interface
- `RESET_ADDR`, 32'd0: PC after reset (program selector entry).
- `ILLOP_ADDR`, 32'd480: vector taken on `trap_illop` or on a fetch outside ROM.
- `XADR_ADDR`, 32'd484: vector taken on `irq`.
- `IMEM_WORDS`, 128: ROM depth in 32-bit words; valid fetch range is PC[31:2] < IMEM_WORDS.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_addr` out 32: byte address to `instr.pc`; always equals the internal PC.
- `imem_data` in 32: word from `instr.id`, combinational from `imem_addr`.
- `br_valid` in 1: branch/jump taken, from execute.
- `br_target` in 32: redirect byte address; bits [1:0] ignored (forced 0).
- `trap_illop` in 1: illegal opcode detected downstream.
- `irq` in 1: level interrupt request; sampled only in RUN.
- `halt_req` in 1: freeze fetch while high.
- `out_valid` out 1: slot holds an instruction.
- `out_ready` in 1: decode consumes the slot this cycle.
- `out_instr` out 32: fetched word (0 when `out_fault`).
- `out_pc` out 32: address of `out_instr`.
- `out_pc_plus4` out 32: `out_pc + 4`, mod 2^32.
- `out_fault` out 1: fetch was outside ROM range.
- `xp_valid` out 1: one-cycle pulse; `xp` must be written to r30.
- `xp` out 32: saved return address for the trap/interrupt.

## Operation
- States: BOOT, RUN, HALT.
  - Reset puts the block in BOOT.
  - BOOT→RUN after exactly one cycle, with no fetch in BOOT.
  - RUN→HALT when `halt_req`=1 and no redirect is pending.
  - HALT→RUN when `halt_req`=0.
  - HALT holds the PC and slot. A valid slot may still drain through `out_ready`.
- Fetch fires when state=RUN, `halt_req`=0, no redirect this cycle, and (`out_valid`=0 or `out_ready`=1).
  - On fire: the slot loads `imem_data`, PC, PC+4 and fault. Then `out_valid`←1 and PC←PC+4.
  - `out_valid`=1 with `out_ready`=1 and no fire: `out_valid`←0.
  - `out_valid`=1 with `out_ready`=0: the slot is held stable, bit-for-bit.
- Redirect priority when several are asserted in one cycle: `irq` > `trap_illop` > `br_valid`. Only the winner acts.
  - Every redirect flushes the slot (`out_valid`←0) and loads the PC with the target: `XADR_ADDR`, `ILLOP_ADDR`, or `{br_target[31:2],2'b00}`.
  - `irq`: `xp`←(`out_valid` ? `out_pc` : PC)+4 and `xp_valid`←1.
  - `trap_illop`: `xp`←`out_pc`+4 and `xp_valid`←1. The slot must be valid; an assertion in the bench checks this.
  - Branches never touch `xp`.
  - Redirects are ignored in BOOT. In HALT they still apply, and the block stays in HALT.
- Out-of-range fetch (PC[31:2] ≥ `IMEM_WORDS`): the slot captures `out_instr`=0 with `out_fault`=1. Decode then raises `trap_illop`.
- PC arithmetic is 32-bit unsigned and wraps at 2^32 to 0. PC[1:0] is always 0.

## Timing
- Reset values:
  - PC and `imem_addr` = `RESET_ADDR`.
  - `out_valid`, `out_fault`, `xp_valid` = 0.
  - `out_instr`, `out_pc`, `xp` = 0; `out_pc_plus4` = 4.
  - State = BOOT.
- First instruction (address `RESET_ADDR`) has `out_valid`=1 in the 2nd cycle after `rst_n` deasserts.
- Fetch-to-slot latency: 1 cycle. Sustained throughput is 1 instruction per cycle with `out_ready` held high.
- Redirect asserted in cycle N:
  - Slot invalid in N+1; `imem_addr`=target in N+1.
  - Target instruction valid in N+2.
  - `xp_valid` high in N+1 only.
- `rst_n` low mid-stream: all state clears asynchronously. No partial slot survives.
- All outputs are registered except `imem_addr`, which is the PC register itself.

## Structure
- Put `RESET_ADDR`/`ILLOP_ADDR`/`XADR_ADDR` defaults, the state encoding (BOOT=0, RUN=1, HALT=2) and the opcode field macros in the shared `risc_constants.vh`.
- Single module. Next-PC selection is the natural split: sub-module `fetch_pc_sel`, purely combinational (priority mux and +4).

## Test plan
- Reset release with `out_ready`=1 → `out_pc` sequence 0, 4, 8, …, with the first valid on cycle 2 and `out_instr` matching ROM words.
- `out_ready`=0 for 3 cycles with the slot at pc=8 → `out_pc`=8 and `out_instr` stable; PC stays at 12 and no fetch occurs.
- `br_valid`=1 with `br_target`=32'd83 at cycle N → slot flushed at N+1; `out_pc`=80 valid at N+2.
- `irq`, `trap_illop` and `br_valid` all asserted together with slot pc=20 → target 484, `xp`=24, `xp_valid` pulses once.
- PC reaches 512 with `IMEM_WORDS`=128 → `out_fault`=1 and `out_instr`=0; `trap_illop` then gives PC=480 and `xp`=516.
- `rst_n` pulsed low mid-stream during HALT → PC=0, `out_valid`=0, state BOOT; restart as in the first scenario.
